reg_status_file: RTL and testbench
==================================

Name: reg_status_file

Overview:
- Parametrised register status table merged with the architectural register file, for the Tomasulo-style out-of-order core.
- Each register holds either a final value (tag == READY_TAG) or the tag of the reservation-station unit that will produce it.
- Issue renames one destination per cycle. A common-data-bus (CDB) broadcast resolves every register waiting on the broadcast tag.
- NRD read ports, with same-cycle CDB bypass, feed operand fetch. A flush input squashes all pending renames.

Parameters:
- NREG, 64, number of registers (power of two); AW = log2(NREG)
- WORD, 32, data width (signed)
- TAG_W, 8, unit-tag width
- READY_TAG, 8'h7F, tag value meaning "value present"
- NRD, 2, number of read ports
- ZERO_REG, 0, if 1 then register 0 always reads ready/0 and ignores all writes

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rd_addr  in  NRD*AW  read register indices, packed, port k at [k*AW +: AW]
- rd_tag  out  NRD*TAG_W  producing-unit tag per port (READY_TAG if ready)
- rd_val  out  NRD*WORD  register value per port; meaningful only when rd_ready
- rd_ready  out  NRD  1 = value valid
- iss_valid  in  1  rename request
- iss_reg  in  AW  destination register
- iss_tag  in  TAG_W  unit tag now owning iss_reg
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  broadcasting unit
- cdb_data  in  WORD  broadcast result
- flush  in  1  squash all pending renames
- pend_cnt  out  AW+1  number of registers currently not ready (registered)

Behaviour:
- State: tag[NREG], val[NREG], pend_cnt. All updates on the rising edge of clk.
- Reset (rst_n=0 at an edge): all tags = READY_TAG, all values = 0, pend_cnt = 0.
  - Reset overrides iss, cdb and flush in the same cycle.
  - Reset mid-operation discards all pending renames.
  - After reset, every rd_ready=1 and every rd_val=0.
- Read (combinational, 0 latency, per port k, r = rd_addr[k]):
  - If tag[r] != READY_TAG and cdb_valid and cdb_tag == tag[r]: rd_ready=1, rd_val=cdb_data, rd_tag=READY_TAG (bypass).
  - Else if tag[r] == READY_TAG: rd_ready=1, rd_val=val[r], rd_tag=READY_TAG.
  - Else: rd_ready=0, rd_tag=tag[r], rd_val=val[r] (stale).
  - Reads never see the same-cycle issue; the new tag is visible the next cycle.
- CDB (cdb_valid and cdb_tag != READY_TAG):
  - Every register i with tag[i] == cdb_tag gets val[i] <= cdb_data and tag[i] <= READY_TAG.
  - Multiple matches are all resolved in the same cycle.
  - cdb_tag == READY_TAG is ignored.
- Issue (iss_valid, iss_tag != READY_TAG, not flush):
  - tag[iss_reg] <= iss_tag; val is unchanged.
  - iss_tag == READY_TAG is ignored.
- Issue and CDB on the same register in the same cycle: val <= cdb_data, tag <= iss_tag. Issue wins the tag.
- Flush: all tags <= READY_TAG, values kept, issue ignored.
  - A CDB value in the same cycle is still written to matching registers.
  - pend_cnt <= 0.
- ZERO_REG=1: register 0 is never renamed or written; its reads always return ready with value 0.
- pend_cnt: next value is the count of non-ready tags after the update, computed from next-state tags. Range 0..NREG.

Decomposition:
- Shared package/define file holds: READY_TAG, WORD_SIZE, UNIT_SIZE, NREG.
- One sub-module: rsf_read_port (a single bypassing read mux), instantiated NRD times via generate.
- Tag-match/update array and pend_cnt popcount stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with iss_valid=1 -> all ports rd_ready=1, rd_val=0, pend_cnt=0.
- Rename then resolve:
  - Cycle 1: iss r5 tag 3 -> next cycle rd r5 gives ready=0, tag=3, pend_cnt=1.
  - Cycle 3: cdb tag 3 data -7 -> same cycle bypass gives ready=1, val=-7; next cycle stored, pend_cnt=0.
- Multi-match: r1 tag 2, later r9 tag 2 (r1 still pending) -> one cdb tag 2 data 100 -> both ready with 100, pend_cnt 0.
- Collision: r4 pending tag 6, then same-cycle iss r4 tag 9 and cdb tag 6 data 55 -> next cycle r4 tag 9 not ready, val 55.
- Flush: 3 registers pending, assert flush with iss r7 tag 1 -> next cycle all ready, old values kept, r7 not renamed, pend_cnt=0.
- Ignored inputs: iss_tag=8'h7F and cdb_tag=8'h7F -> no state change. With ZERO_REG=1, iss r0 tag 4 -> r0 still ready/0.

Source files
------------

// File: rtl/reg_status_file_pkg.sv
// Shared defaults for the merged register status table / register file.
// Instances may override these through the top-level parameters.
package reg_status_file_pkg;

    localparam int unsigned NREG      = 64;
    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned UNIT_SIZE = 8;
    localparam logic [UNIT_SIZE-1:0] READY_TAG = 8'h7F;

endpackage

// File: rtl/rsf_read_port.sv
// One operand-fetch read mux: selects the stored entry or the same-cycle CDB
// result when the entry is waiting on the broadcasting unit.
module rsf_read_port
    import reg_status_file_pkg::*;
#(
    parameter int unsigned WORD   = WORD_SIZE,
    parameter int unsigned TAG_W  = UNIT_SIZE,
    parameter logic [TAG_W-1:0] RDY_TAG = TAG_W'(READY_TAG)
) (
    input  logic [TAG_W-1:0] reg_tag_i,
    input  logic [WORD-1:0]  reg_val_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [WORD-1:0]  cdb_data_i,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [WORD-1:0]  rd_val_o,
    output logic             rd_ready_o
);

    logic pending;
    logic bypass;

    assign pending = (reg_tag_i != RDY_TAG);
    assign bypass  = pending && cdb_valid_i && (cdb_tag_i == reg_tag_i);

    always_comb begin
        rd_tag_o   = RDY_TAG;
        rd_val_o   = reg_val_i;
        rd_ready_o = 1'b1;
        if (bypass) begin
            rd_val_o = cdb_data_i;
        end else if (pending) begin
            // Not ready: expose the producing unit, value is stale.
            rd_tag_o   = reg_tag_i;
            rd_ready_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_status_file.sv
// Register status table merged with the architectural register file: rename on
// issue, resolve on CDB broadcast, squash on flush, NRD bypassing read ports.
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int unsigned NREG      = reg_status_file_pkg::NREG,
    parameter int unsigned WORD      = WORD_SIZE,
    parameter int unsigned TAG_W     = UNIT_SIZE,
    parameter logic [TAG_W-1:0] READY_TAG = TAG_W'(reg_status_file_pkg::READY_TAG),
    parameter int unsigned NRD       = 2,
    parameter bit          ZERO_REG  = 1'b0,
    localparam int unsigned AW       = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*TAG_W-1:0] rd_tag,
    output logic [NRD*WORD-1:0]  rd_val,
    output logic [NRD-1:0]       rd_ready,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_reg,
    input  logic [TAG_W-1:0]     iss_tag,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [WORD-1:0]      cdb_data,
    input  logic                 flush,
    output logic [AW:0]          pend_cnt
);

    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_d [NREG];
    logic [WORD-1:0]  val_q [NREG];
    logic [WORD-1:0]  val_d [NREG];
    logic [AW:0]      pend_cnt_q;
    logic [AW:0]      pend_cnt_d;

    logic cdb_en;
    logic iss_en;

    // A READY_TAG broadcast or rename would be indistinguishable from "ready".
    assign cdb_en = cdb_valid && (cdb_tag != READY_TAG);
    assign iss_en = iss_valid && (iss_tag != READY_TAG) && !flush;

    always_comb begin
        pend_cnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            tag_d[i] = tag_q[i];
            val_d[i] = val_q[i];
            if (cdb_en && (tag_q[i] == cdb_tag)) begin
                val_d[i] = cdb_data;
                tag_d[i] = READY_TAG;
            end
            if (flush) begin
                tag_d[i] = READY_TAG;
            end
            // Issue wins the tag over a same-cycle CDB resolve.
            if (iss_en && (iss_reg == AW'(i))) begin
                tag_d[i] = iss_tag;
            end
            if (ZERO_REG && (i == 0)) begin
                tag_d[i] = READY_TAG;
                val_d[i] = '0;
            end
            if (tag_d[i] != READY_TAG) begin
                pend_cnt_d = pend_cnt_d + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                tag_q[i] <= READY_TAG;
                val_q[i] <= '0;
            end
            pend_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                tag_q[i] <= tag_d[i];
                val_q[i] <= val_d[i];
            end
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[k*AW +: AW];

        rsf_read_port #(
            .WORD    (WORD),
            .TAG_W   (TAG_W),
            .RDY_TAG (READY_TAG)
        ) u_rd (
            .reg_tag_i   (tag_q[addr]),
            .reg_val_i   (val_q[addr]),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .rd_tag_o    (rd_tag[k*TAG_W +: TAG_W]),
            .rd_val_o    (rd_val[k*WORD +: WORD]),
            .rd_ready_o  (rd_ready[k])
        );
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: one ZERO_REG=1 instance under test plus a
// ZERO_REG=0 twin driven identically to contrast register-0 behaviour.
module tb_reg_status_file;

    localparam int unsigned AW = 6;

    logic          clk;
    logic          rst_n;
    logic [11:0]   rd_addr;
    logic [15:0]   rd_tag, rd_tag0;
    logic [63:0]   rd_val, rd_val0;
    logic [1:0]    rd_ready, rd_ready0;
    logic          iss_valid;
    logic [5:0]    iss_reg;
    logic [7:0]    iss_tag;
    logic          cdb_valid;
    logic [7:0]    cdb_tag;
    logic [31:0]   cdb_data;
    logic          flush;
    logic [6:0]    pend_cnt, pend_cnt0;

    int n_assert;
    int n_fail;

    reg_status_file #(
        .ZERO_REG (1'b1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_tag    (rd_tag),
        .rd_val    (rd_val),
        .rd_ready  (rd_ready),
        .iss_valid (iss_valid),
        .iss_reg   (iss_reg),
        .iss_tag   (iss_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .flush     (flush),
        .pend_cnt  (pend_cnt)
    );

    reg_status_file #(
        .ZERO_REG (1'b0)
    ) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_tag    (rd_tag0),
        .rd_val    (rd_val0),
        .rd_ready  (rd_ready0),
        .iss_valid (iss_valid),
        .iss_reg   (iss_reg),
        .iss_tag   (iss_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .flush     (flush),
        .pend_cnt  (pend_cnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Check one read port of the ZERO_REG=1 instance.
    task automatic chk_rd(input string name, input int k, input logic exp_rdy,
                          input logic [7:0] exp_tag, input logic [31:0] exp_val);
        chk({name, ".ready"}, 32'(rd_ready[k]), 32'(exp_rdy));
        chk({name, ".tag"}, 32'(rd_tag[k*8 +: 8]), 32'(exp_tag));
        chk({name, ".val"}, rd_val[k*32 +: 32], exp_val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {6'(a1), 6'(a0)};
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        iss_reg   = '0;
        iss_tag   = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        flush     = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle();
        set_rd(5, 9);

        // Reset held two cycles while an issue is requested.
        rst_n     = 1'b0;
        iss_valid = 1'b1;
        iss_reg   = 6'd5;
        iss_tag   = 8'd3;
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        chk_rd("rst_p0", 0, 1'b1, 8'h7F, 32'd0);
        chk_rd("rst_p1", 1, 1'b1, 8'h7F, 32'd0);
        chk("rst_pend", 32'(pend_cnt), 32'd0);

        // Rename r5 -> tag 3, then resolve with -7.
        iss_valid = 1'b1;
        iss_reg   = 6'd5;
        iss_tag   = 8'd3;
        settle();
        chk_rd("iss_same_cycle", 0, 1'b1, 8'h7F, 32'd0);
        tick();
        idle();
        settle();
        chk_rd("renamed_r5", 0, 1'b0, 8'd3, 32'd0);
        chk("renamed_pend", 32'(pend_cnt), 32'd1);
        cdb_valid = 1'b1;
        cdb_tag   = 8'd3;
        cdb_data  = -32'sd7;
        settle();
        chk_rd("bypass_r5", 0, 1'b1, 8'h7F, 32'hFFFF_FFF9);
        tick();
        idle();
        settle();
        chk_rd("stored_r5", 0, 1'b1, 8'h7F, 32'hFFFF_FFF9);
        chk("stored_pend", 32'(pend_cnt), 32'd0);

        // Two registers waiting on tag 2, one broadcast resolves both.
        set_rd(1, 9);
        iss_valid = 1'b1;
        iss_reg   = 6'd1;
        iss_tag   = 8'd2;
        tick();
        iss_reg = 6'd9;
        tick();
        idle();
        settle();
        chk_rd("multi_wait_r1", 0, 1'b0, 8'd2, 32'd0);
        chk_rd("multi_wait_r9", 1, 1'b0, 8'd2, 32'd0);
        chk("multi_wait_pend", 32'(pend_cnt), 32'd2);
        cdb_valid = 1'b1;
        cdb_tag   = 8'd2;
        cdb_data  = 32'd100;
        tick();
        idle();
        settle();
        chk_rd("multi_res_r1", 0, 1'b1, 8'h7F, 32'd100);
        chk_rd("multi_res_r9", 1, 1'b1, 8'h7F, 32'd100);
        chk("multi_res_pend", 32'(pend_cnt), 32'd0);

        // Issue and CDB hit r4 in the same cycle.
        set_rd(4, 5);
        iss_valid = 1'b1;
        iss_reg   = 6'd4;
        iss_tag   = 8'd6;
        tick();
        iss_tag   = 8'd9;
        cdb_valid = 1'b1;
        cdb_tag   = 8'd6;
        cdb_data  = 32'd55;
        tick();
        idle();
        settle();
        chk_rd("collide_r4", 0, 1'b0, 8'd9, 32'd55);
        chk("collide_pend", 32'(pend_cnt), 32'd1);

        // Three pending (r4, r10, r12), then flush with issue r7 and CDB tag 11.
        iss_valid = 1'b1;
        iss_reg   = 6'd10;
        iss_tag   = 8'd11;
        tick();
        iss_reg = 6'd12;
        iss_tag = 8'd12;
        tick();
        idle();
        settle();
        chk("pre_flush_pend", 32'(pend_cnt), 32'd3);
        flush     = 1'b1;
        iss_valid = 1'b1;
        iss_reg   = 6'd7;
        iss_tag   = 8'd1;
        cdb_valid = 1'b1;
        cdb_tag   = 8'd11;
        cdb_data  = 32'd77;
        tick();
        idle();
        set_rd(4, 10);
        settle();
        chk_rd("flush_r4", 0, 1'b1, 8'h7F, 32'd55);
        chk_rd("flush_r10", 1, 1'b1, 8'h7F, 32'd77);
        set_rd(12, 7);
        settle();
        chk_rd("flush_r12", 0, 1'b1, 8'h7F, 32'd0);
        chk_rd("flush_r7", 1, 1'b1, 8'h7F, 32'd0);
        chk("flush_pend", 32'(pend_cnt), 32'd0);

        // READY_TAG issue and broadcast are ignored.
        set_rd(3, 5);
        iss_valid = 1'b1;
        iss_reg   = 6'd3;
        iss_tag   = 8'h7F;
        cdb_valid = 1'b1;
        cdb_tag   = 8'h7F;
        cdb_data  = 32'd999;
        settle();
        chk_rd("ign_bypass_r5", 1, 1'b1, 8'h7F, 32'hFFFF_FFF9);
        tick();
        idle();
        settle();
        chk_rd("ign_r3", 0, 1'b1, 8'h7F, 32'd0);
        chk_rd("ign_r5", 1, 1'b1, 8'h7F, 32'hFFFF_FFF9);
        chk("ign_pend", 32'(pend_cnt), 32'd0);

        // Register 0: pinned with ZERO_REG=1, ordinary in the twin.
        set_rd(0, 5);
        iss_valid = 1'b1;
        iss_reg   = 6'd0;
        iss_tag   = 8'd4;
        tick();
        idle();
        settle();
        chk_rd("zr_r0", 0, 1'b1, 8'h7F, 32'd0);
        chk("zr_pend", 32'(pend_cnt), 32'd0);
        chk("twin_r0_ready", 32'(rd_ready0[0]), 32'd0);
        chk("twin_r0_tag", 32'(rd_tag0[7:0]), 32'd4);
        chk("twin_pend", 32'(pend_cnt0), 32'd1);
        cdb_valid = 1'b1;
        cdb_tag   = 8'd4;
        cdb_data  = 32'd42;
        tick();
        idle();
        settle();
        chk_rd("zr_r0_cdb", 0, 1'b1, 8'h7F, 32'd0);
        chk("twin_r0_val", rd_val0[31:0], 32'd42);
        chk("twin_r0_rdy2", 32'(rd_ready0[0]), 32'd1);

        // Reset mid-operation discards a pending rename and all values.
        set_rd(20, 5);
        iss_valid = 1'b1;
        iss_reg   = 6'd20;
        iss_tag   = 8'd8;
        tick();
        idle();
        settle();
        chk("mid_pend_before", 32'(pend_cnt), 32'd1);
        rst_n     = 1'b0;
        iss_valid = 1'b1;
        iss_reg   = 6'd5;
        iss_tag   = 8'd1;
        cdb_valid = 1'b1;
        cdb_tag   = 8'd8;
        cdb_data  = 32'd5;
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        chk_rd("mid_rst_r20", 0, 1'b1, 8'h7F, 32'd0);
        chk_rd("mid_rst_r5", 1, 1'b1, 8'h7F, 32'd0);
        chk("mid_rst_pend", 32'(pend_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
